nes_poll_scheduler: RTL
=======================

Name: nes_poll_scheduler

Overview:
- Sequences the NES serial-controller protocol for two gamepad ports that share latch and sclk and have separate data lines.
- Starts frames periodically (vertical-rate poll) or on demand, and coalesces requests.
- Samples 8 bits per port and publishes active-high button bytes with valid and changed strobes.
- Sits between the pad connectors and the game or CPU logic. It is the single owner of the latch and sclk lines.

Parameters:
- HALF_PERIOD_CYC, 300: clk cycles per protocol half-period tick (6 us at 50 MHz). Must be >= 4.
- POLL_INTERVAL_CYC, 833333: clk cycles between automatic polls (60 Hz at 50 MHz). Must be greater than the frame length.
- NUM_BITS, 8: bits shifted per frame. Fixed at 8 for NES pads.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: allows new frames to start (automatic and manual).
- poll_req, in, 1: one-cycle manual poll request.
- data0, in, 1: port 0 serial data, active-low, asynchronous.
- data1, in, 1: port 1 serial data, active-low, asynchronous.
- latch, out, 1: shared latch to both pads.
- sclk, out, 1: shared shift clock to both pads.
- busy, out, 1: high while a frame is in progress.
- buttons0, out, 8: port 0 buttons, 1 = pressed. Bit 0 = A, 1 = B, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right.
- buttons1, out, 8: port 1 buttons, same encoding.
- frame_valid, out, 1: one-cycle pulse when buttons0 and buttons1 are updated.
- changed, out, 1: one-cycle pulse, coincident with frame_valid, when either published byte differs from its previous value.

Behaviour:
- Reset: state IDLE. All outputs are 0: latch, sclk, busy, buttons0, buttons1, frame_valid, changed. Interval counter, pending flag, bit counter and synchronizers are all cleared.
- Reset mid-frame: abort immediately. latch and sclk go low on the next edge and no frame_valid is produced.
- Input sync: data0 and data1 each pass through a 2-flop synchronizer. All sampling uses the synchronized values.
- Interval counter:
  - Counts while enable=1. When it reaches POLL_INTERVAL_CYC-1 it wraps to 0 and sets pending.
  - When enable=0 it is held at 0.
- Manual requests: poll_req with enable=1 sets pending.
- Request coalescing: requests arriving while busy also set pending. Multiple requests collapse into exactly one follow-up frame.
- Tick generator:
  - Counts only while busy and is cleared to 0 on frame start.
  - Asserts tick for one cycle every HALF_PERIOD_CYC cycles.
- FSM states: IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - Outputs: latch=0, sclk=0, busy=0.
  - If pending and enable, go to LATCH, clear pending and clear the bit counter.
  - If pending and the interval wrap occur in the same cycle, start one frame only.
- LATCH: latch=1, busy=1. Stays for 2 ticks, then goes to SHIFT_LO.
- SHIFT_LO:
  - Outputs: latch=0, sclk=0.
  - On tick, sample the inverted synced data0 and data1 into raw0[bit] and raw1[bit].
  - If bit==7, go to DONE. Otherwise go to SHIFT_HI.
- SHIFT_HI: sclk=1. On tick, increment bit and go to SHIFT_LO.
- DONE:
  - Lasts one cycle. Load buttons from raw and pulse frame_valid.
  - Pulse changed if (raw0 != buttons0) or (raw1 != buttons1).
  - Go to IDLE. A pending request starts its frame on the following cycle.
- Frame length:
  - 17 ticks: 2 latch, 8 low, 7 high, giving 7 sclk rising edges.
  - frame_valid fires 1 cycle after the last sample, i.e. 17*HALF_PERIOD_CYC+1 cycles after entering LATCH.
- enable dropping mid-frame: the frame completes normally. Pending is retained but does not start a frame until enable returns.
- Unplugged pad: data floats high (pull-up), which reads as 0x00. This is not an error.

Optional Feature:
- Macro: NES_DEBOUNCE_EN.
- When defined:
  - Keep the previous raw frame per port.
  - buttonsN is updated in DONE only if rawN equals the previous raw frame for that port.
  - frame_valid still pulses every frame. changed reflects only the published values.
  - Previous-raw registers reset to 0.
- When undefined: publish every frame directly, with no extra registers.

Decomposition:
- Package nes_pkg:
  - FSM state enum.
  - Button bit index constants (BTN_A … BTN_RIGHT).
  - NES_BITS=8 and LATCH_TICKS=2.
- Sub-module nes_tick_gen:
  - Parameter HALF_PERIOD_CYC.
  - Ports: clk, reset, clear, run, tick.
  - Its counter width is $clog2(HALF_PERIOD_CYC).

Test Plan (HALF_PERIOD_CYC=4, POLL_INTERVAL_CYC=200, pad models shift on sclk rising edge, load on latch):
- Basic read:
  - Stimulus: pad0 holds A+Start (active-high 0x09), pad1 holds Right (0x80); pulse poll_req.
  - Response: latch high for 8 cycles, 7 sclk pulses each 4 high / 4 low, frame_valid 69 cycles after LATCH entry.
  - Response: buttons0=0x09, buttons1=0x80, changed=1.
- Repeat frame: identical pads, second poll → frame_valid=1, changed=0, outputs unchanged.
- Automatic polling and coalescing:
  - Stimulus: enable=1 with no poll_req; then 3 poll_req pulses during one busy frame.
  - Response: a frame starts every 200 cycles; the 3 pulses yield exactly one extra frame directly after.
- Gating and reset:
  - Stimulus: enable=0 for 1000 cycles; separately, reset asserted in SHIFT_HI at bit 3.
  - Response: no latch activity while enable=0.
  - Response: after reset, latch=sclk=0 next cycle, buttons=0x00, no frame_valid; a subsequent poll reads correctly.
- Unplugged pad: data1 tied high, pad0 = all buttons (0xFF) → buttons0=0xFF, buttons1=0x00.
- Debounce (NES_DEBOUNCE_EN):
  - Stimulus: pad0 sequence of frames 0x01, 0x02, 0x02.
  - Response: buttons0 stays 0x00 for frames 1 and 2, becomes 0x02 on frame 3, with changed pulsing only on frame 3.

Source files
------------

// File: rtl/nes_pkg.sv
// nes_pkg: shared types and constants for the NES gamepad poll scheduler.
//   state_t      - frame sequencer states
//   BTN_*        - bit positions of each button in the published bytes
//   NES_BITS     - bits shifted per frame
//   LATCH_TICKS  - half-period ticks the latch pulse is held high
package nes_pkg;

  localparam int unsigned NES_BITS    = 8;
  localparam int unsigned LATCH_TICKS = 2;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

endpackage

// File: rtl/nes_tick_gen.sv
// nes_tick_gen: half-period tick generator for the pad protocol.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count from 0 (frame start)
//   run        : count enable (high while a frame is in progress)
//   tick       : one-cycle pulse every HALF_PERIOD_CYC running cycles
module nes_tick_gen #(
  parameter int unsigned HALF_PERIOD_CYC = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(HALF_PERIOD_CYC);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    tick = run && (cnt == LAST);
  end

endmodule

// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: drives the shared latch/sclk of two NES gamepad ports,
// samples both data lines and publishes active-high button bytes.
//   clk, reset        : system clock, synchronous active-high reset
//   enable            : allows new frames to start
//   poll_req          : one-cycle manual poll request
//   data0, data1      : asynchronous active-low serial data from each pad
//   latch, sclk       : shared pad control lines
//   busy              : frame in progress
//   buttons0/buttons1 : published buttons, 1 = pressed (bit 0 = A .. 7 = Right)
//   frame_valid       : one-cycle pulse when the button bytes are updated
//   changed           : pulse with frame_valid when either byte changed
// Build option: define NES_DEBOUNCE_EN to publish a port only when two
// consecutive raw frames agree.
module nes_poll_scheduler
  import nes_pkg::*;
#(
  parameter int unsigned HALF_PERIOD_CYC   = 300,
  parameter int unsigned POLL_INTERVAL_CYC = 833333,
  parameter int unsigned NUM_BITS          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  input  logic       data0,
  input  logic       data1,
  output logic       latch,
  output logic       sclk,
  output logic       busy,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       frame_valid,
  output logic       changed
);

  localparam int unsigned IW = $clog2(POLL_INTERVAL_CYC);
  localparam logic [IW-1:0] IV_LAST   = IW'(POLL_INTERVAL_CYC - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(NUM_BITS - 1);
  localparam logic [2:0]    LATCH_END = 3'(LATCH_TICKS - 1);

  state_t state, state_next;

  logic [1:0]    sync0, sync1;
  logic [IW-1:0] ival_cnt;
  logic          ival_wrap;
  logic          pending;
  logic          start;
  logic          tick;
  logic [2:0]    bit_cnt;
  logic [7:0]    raw0, raw1;
  logic [7:0]    pub0, pub1;

  // Input synchronizers; sync*[1] is the settled value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[0], data0};
      sync1 <= {sync1[0], data1};
    end
  end

  always_comb begin
    ival_wrap = enable && (ival_cnt == IV_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset || !enable || ival_wrap) begin
      ival_cnt <= '0;
    end else begin
      ival_cnt <= ival_cnt + 1'b1;
    end
  end

  // Frame start consumes every request seen so far, including one arriving
  // in the same cycle, so coincident requests yield a single frame.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      pending <= 1'b0;
    end else if (ival_wrap || (poll_req && enable)) begin
      pending <= 1'b1;
    end
  end

  nes_tick_gen #(
    .HALF_PERIOD_CYC(HALF_PERIOD_CYC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(start),
    .run  (busy),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    latch      = 1'b0;
    sclk       = 1'b0;
    busy       = 1'b1;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pending && enable) begin
          start      = 1'b1;
          state_next = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch = 1'b1;
        if (tick && (bit_cnt == LATCH_END)) state_next = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (tick) state_next = (bit_cnt == LAST_BIT) ? ST_DONE : ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        sclk = 1'b1;
        if (tick) state_next = ST_SHIFT_LO;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // bit_cnt doubles as the latch-tick counter before the shift phase.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      bit_cnt <= '0;
    end else if (tick) begin
      if (state == ST_LATCH) begin
        bit_cnt <= (bit_cnt == LATCH_END) ? '0 : bit_cnt + 1'b1;
      end else if (state == ST_SHIFT_HI) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw0 <= '0;
      raw1 <= '0;
    end else if ((state == ST_SHIFT_LO) && tick) begin
      raw0[bit_cnt] <= ~sync0[1];
      raw1[bit_cnt] <= ~sync1[1];
    end
  end

`ifdef NES_DEBOUNCE_EN
  logic [7:0] prev0, prev1;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev0 <= '0;
      prev1 <= '0;
    end else if (state == ST_DONE) begin
      prev0 <= raw0;
      prev1 <= raw1;
    end
  end

  always_comb begin
    pub0 = (raw0 == prev0) ? raw0 : buttons0;
    pub1 = (raw1 == prev1) ? raw1 : buttons1;
  end
`else
  always_comb begin
    pub0 = raw0;
    pub1 = raw1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      buttons0    <= '0;
      buttons1    <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      if (state == ST_DONE) begin
        buttons0    <= pub0;
        buttons1    <= pub1;
        frame_valid <= 1'b1;
        changed     <= (pub0 != buttons0) || (pub1 != buttons1);
      end
    end
  end

endmodule
